// File: rtl/param_mem_ctrl.sv
// -----------------------------------------------------------------------------
// param_mem_ctrl
//   Single-port word memory with a self-clearing controller. After reset the
//   whole array is swept to zero one word per cycle (busy=1). Afterwards it
//   accepts one read or byte-masked write per cycle. Read data returns
//   READ_LAT cycles after the accepting edge, in issue order.
//
// Parameters
//   DATA_W    data word width in bits (multiple of 8)
//   ADDR_W    word address width; depth is 2**ADDR_W words
//   READ_LAT  read latency in cycles (1..4)
//
// Ports
//   clk        clock, all state updates on the rising edge
//   reset      synchronous active-high reset
//   req_valid  request present
//   req_ready  controller accepts a request this cycle
//   req_we     1 = write, 0 = read
//   req_be     per-byte write enable, bit i covers datIn[8i+7:8i]
//   adrs       word address
//   datIn      write data
//   rsp_valid  one-cycle pulse; datOut carries read data
//   datOut     read data, held between responses
//   busy       high while the clear sweep runs
// -----------------------------------------------------------------------------
module param_mem_ctrl #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 10,
    parameter int READ_LAT = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [DATA_W/8-1:0] req_be,
    input  logic [ADDR_W-1:0]   adrs,
    input  logic [DATA_W-1:0]   datIn,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   datOut,
    output logic                busy
);

    localparam int BE_W  = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];

    // Stage 0 snapshots the memory at the accepting edge; stages 1..READ_LAT
    // only delay it, so the last stage rises exactly READ_LAT edges later.
    logic [READ_LAT:0]   rd_vld_q;
    logic [DATA_W-1:0]   rd_data_q [READ_LAT+1];

    logic                accept;
    logic                wr_en;
    logic                rd_en;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    // NOTE: defaults assigned first so no path through the block can leave a
    // variable unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        unique case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                // Last word of the sweep is written on this edge.
                if (clr_cnt_q == '1) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy      = (state_q == ST_CLEAR);
        req_ready = (state_q == ST_READY);
    end

    assign accept = req_valid && req_ready;
    assign wr_en  = accept && req_we;
    assign rd_en  = accept && !req_we;

    // ------------------------------------------------------------------
    // Memory array: sweep writes zeros, requests write enabled bytes
    // ------------------------------------------------------------------
    // NOTE: the array has no reset term; it is zeroed by the sweep, which
    // keeps it mappable onto RAM macros.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (busy) begin
                mem_q[clr_cnt_q] <= '0;
            end else if (wr_en) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (req_be[b]) begin
                        mem_q[adrs][8*b +: 8] <= datIn[8*b +: 8];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline; reset drops every in-flight read
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_vld_q <= '0;
            for (int i = 0; i <= READ_LAT; i++) begin
                rd_data_q[i] <= '0;
            end
        end else begin
            rd_vld_q[0] <= rd_en;
            if (rd_en) begin
                rd_data_q[0] <= mem_q[adrs];
            end
            for (int i = 1; i <= READ_LAT; i++) begin
                rd_vld_q[i] <= rd_vld_q[i-1];
                // Data moves only with a valid token, so the final stage
                // (datOut) holds between responses.
                if (rd_vld_q[i-1]) begin
                    rd_data_q[i] <= rd_data_q[i-1];
                end
            end
        end
    end

    assign rsp_valid = rd_vld_q[READ_LAT];
    assign datOut    = rd_data_q[READ_LAT];

endmodule

// File: tb/tb_param_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_param_mem_ctrl
//   Self-checking bench for param_mem_ctrl (DATA_W=16, ADDR_W=4, READ_LAT=2).
//   Every cycle is compared against a behavioural model: an array of words,
//   a count of remaining clear cycles and a queue of pending responses with
//   their due edge. Hand-written sequences and a vector table cover the
//   corner cases; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_param_mem_ctrl;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int RL    = 2;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_be;
    logic [AW-1:0] adrs;
    logic [DW-1:0] datIn;
    logic          rsp_valid;
    logic [DW-1:0] datOut;
    logic          busy;

    always #5 clk = ~clk;

    param_mem_ctrl #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .READ_LAT (RL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_be    (req_be),
        .adrs      (adrs),
        .datIn     (datIn),
        .rsp_valid (rsp_valid),
        .datOut    (datOut),
        .busy      (busy)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rsp_t;

    logic [DW-1:0] m_mem [DEPTH];
    int            m_clear_left = 0;
    rsp_t          m_q [$];
    logic [DW-1:0] m_dout = '0;
    int            edge_n = 0;

    logic          last_rv;
    logic [DW-1:0] last_dout;

    // Apply one cycle of inputs, advance the model over the edge, compare.
    task automatic tick(input logic r, input logic v, input logic we,
                        input logic [1:0] be, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
        logic exp_rv;
        reset     = r;
        req_valid = v;
        req_we    = we;
        req_be    = be;
        adrs      = a;
        datIn     = d;
        @(posedge clk);
        edge_n++;
        if (r) begin
            m_clear_left = DEPTH;
            m_q.delete();
            m_dout = '0;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        end else if (m_clear_left > 0) begin
            m_clear_left--;
        end else if (v) begin
            if (we) begin
                for (int b = 0; b < 2; b++)
                    if (be[b]) m_mem[a][8*b +: 8] = d[8*b +: 8];
            end else begin
                m_q.push_back('{due: edge_n + RL, data: m_mem[a]});
            end
        end
        exp_rv = 1'b0;
        if (!r && m_q.size() > 0 && m_q[0].due == edge_n) begin
            exp_rv = 1'b1;
            m_dout = m_q[0].data;
            void'(m_q.pop_front());
        end
        #1;
        check("busy",      32'(busy),      32'(m_clear_left > 0));
        check("req_ready", 32'(req_ready), 32'(m_clear_left == 0));
        check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        check("datOut",    32'(datOut),    32'(m_dout));
        last_rv   = rsp_valid;
        last_dout = datOut;
    endtask

    // Run cycles until req_ready rises (bounded), optionally holding a read
    // request. Reports cycle count and number of responses seen.
    task automatic clear_wait(input logic hold_v, input logic [AW-1:0] hold_a,
                              output int cycles, output int pulses);
        cycles = 0;
        pulses = 0;
        do begin
            tick(1'b0, hold_v, 1'b0, 2'b00, hold_a, '0);
            cycles++;
            if (last_rv) pulses++;
        end while (!req_ready && cycles < 40);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          v;
        logic          we;
        logic [1:0]    be;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          rv;
        logic [DW-1:0] dout;
    } vec_t;

    vec_t vecs [13];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, pul, n;

        vecs[0]  = '{v:1, we:1, be:2'b11, a:3, d:16'hABCD, rv:0, dout:16'h0000};
        vecs[1]  = '{v:1, we:1, be:2'b01, a:3, d:16'h1234, rv:0, dout:16'h0000};
        vecs[2]  = '{v:1, we:0, be:2'b00, a:3, d:16'h0000, rv:0, dout:16'h0000};
        vecs[3]  = '{v:0, we:0, be:2'b00, a:0, d:16'h0000, rv:0, dout:16'h0000};
        vecs[4]  = '{v:0, we:0, be:2'b00, a:0, d:16'h0000, rv:1, dout:16'hAB34};
        vecs[5]  = '{v:1, we:1, be:2'b00, a:3, d:16'hFFFF, rv:0, dout:16'h0000};
        vecs[6]  = '{v:1, we:0, be:2'b00, a:3, d:16'h0000, rv:0, dout:16'h0000};
        vecs[7]  = '{v:0, we:0, be:2'b00, a:0, d:16'h0000, rv:0, dout:16'h0000};
        vecs[8]  = '{v:0, we:0, be:2'b00, a:0, d:16'h0000, rv:1, dout:16'hAB34};
        vecs[9]  = '{v:1, we:1, be:2'b11, a:7, d:16'h5A5A, rv:0, dout:16'h0000};
        vecs[10] = '{v:1, we:0, be:2'b00, a:7, d:16'h0000, rv:0, dout:16'h0000};
        vecs[11] = '{v:0, we:0, be:2'b00, a:0, d:16'h0000, rv:0, dout:16'h0000};
        vecs[12] = '{v:0, we:0, be:2'b00, a:0, d:16'h0000, rv:1, dout:16'h5A5A};

        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_be = '0; adrs = '0; datIn = '0;

        // Reset state and clear sweep length.
        tick(1'b1, 0, 0, 2'b00, 0, 0);
        check("reset_busy",   32'(busy),      32'd1);
        check("reset_ready",  32'(req_ready), 32'd0);
        check("reset_datOut", 32'(datOut),    32'h0);
        clear_wait(1'b0, '0, cyc, pul);
        check("clear_len", 32'(cyc), 32'd16);

        // Every word reads back zero after the sweep.
        n = 0;
        for (int a = 0; a < DEPTH + RL; a++) begin
            tick(1'b0, a < DEPTH, 1'b0, 2'b00, AW'(a), '0);
            if (last_rv) begin
                n++;
                check("clear_data", 32'(last_dout), 32'h0);
            end
        end
        check("clear_rsp_cnt", 32'(n), 32'd16);

        // Back-to-back writes then back-to-back reads.
        for (int a = 0; a < 5; a++) tick(1'b0, 1'b1, 1'b1, 2'b11, AW'(a), DW'(a));
        for (int i = 0; i < 7; i++) begin
            tick(1'b0, i < 5, 1'b0, 2'b00, AW'(i), '0);
            if (i < 2) check("b2b_early", 32'(last_rv), 32'd0);
            else begin
                check("b2b_rv",   32'(last_rv),   32'd1);
                check("b2b_data", 32'(last_dout), 32'(i - 2));
            end
        end

        // Byte enables, zero-mask write, write-then-read next cycle.
        for (int i = 0; i < 13; i++) begin
            tick(1'b0, vecs[i].v, vecs[i].we, vecs[i].be, vecs[i].a, vecs[i].d);
            check($sformatf("vec%0d_rv", i), 32'(last_rv), 32'(vecs[i].rv));
            if (vecs[i].rv) check($sformatf("vec%0d_dout", i), 32'(last_dout), 32'(vecs[i].dout));
        end

        // Reset with two reads in flight.
        tick(1'b0, 1'b1, 1'b0, 2'b00, 3, '0);
        tick(1'b0, 1'b1, 1'b0, 2'b00, 7, '0);
        tick(1'b1, 1'b0, 1'b0, 2'b00, 0, '0);
        check("inflight_rv",   32'(last_rv),   32'd0);
        check("inflight_dout", 32'(last_dout), 32'h0);
        clear_wait(1'b0, '0, cyc, pul);
        check("reclear_len",    32'(cyc), 32'd16);
        check("reclear_pulses", 32'(pul), 32'd0);
        tick(1'b0, 1'b1, 1'b0, 2'b00, 3, '0);
        tick(1'b0, 1'b1, 1'b0, 2'b00, 7, '0);
        tick(1'b0, 1'b0, 1'b0, 2'b00, 0, '0);
        check("reclear_rv3",  32'(last_rv),   32'd1);
        check("reclear_d3",   32'(last_dout), 32'h0);
        tick(1'b0, 1'b0, 1'b0, 2'b00, 0, '0);
        check("reclear_rv7",  32'(last_rv),   32'd1);
        check("reclear_d7",   32'(last_dout), 32'h0);

        // Request held through the sweep is taken on the first ready cycle.
        tick(1'b1, 1'b1, 1'b0, 2'b00, 2, '0);
        clear_wait(1'b1, 2, cyc, pul);
        check("held_clear_len", 32'(cyc), 32'd16);
        check("held_no_rsp",    32'(pul), 32'd0);
        tick(1'b0, 1'b1, 1'b0, 2'b00, 2, '0);
        tick(1'b0, 1'b0, 1'b0, 2'b00, 0, '0);
        check("held_rv_early", 32'(last_rv), 32'd0);
        tick(1'b0, 1'b0, 1'b0, 2'b00, 0, '0);
        check("held_rv", 32'(last_rv), 32'd1);
        tick(1'b0, 1'b0, 1'b0, 2'b00, 0, '0);
        check("held_single", 32'(last_rv), 32'd0);

        // Randomized traffic, with occasional resets, against the model.
        for (int i = 0; i < 600; i++) begin
            tick($urandom_range(0, 149) == 0,
                 $urandom_range(0, 9) < 7,
                 $urandom_range(0, 1) == 1,
                 2'($urandom_range(0, 3)),
                 AW'($urandom_range(0, DEPTH - 1)),
                 DW'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
